axi_full_mst_burst: RTL and testbench

AXI_FULL_MST_BURST -- requirements
Module: axi_full_mst_burst

---
 rtl/axi_full_pkg.sv | 30 +++
 rtl/axi_full_mst_burst.sv | 235 +++++++++++++++++++++++
 tb/tb_axi_full_mst_burst.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_full_pkg.sv
// Shared definitions for the AXI4 full burst master: FSM states, AXI burst and
// response encodings, and the 4 KB boundary test used at command acceptance.
package axi_full_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WADDR,
        WDATA,
        WRESP,
        RADDR,
        RDATA,
        FIN
    } state_t;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // True when a burst starting at page offset `offset` of (len+1) beats of
    // `nbytes` bytes each runs past the end of its 4 KB page. Ending exactly
    // on the boundary is legal.
    function automatic logic crosses_4k(input logic [11:0] offset,
                                        input logic [7:0]  len,
                                        input logic [3:0]  nbytes);
        logic [15:0] span;
        span = (16'(len) + 16'd1) * 16'(nbytes);
        return (16'(offset) + span) > 16'h1000;
    endfunction

endpackage

// File: rtl/axi_full_mst_burst.sv
// Single-command AXI4 INCR burst master. A command is checked for alignment and
// 4 KB crossing, then run as one write (AW, W stream, B) or one read (AR, R
// stream) burst. DONE pulses once per command with the worst response seen.
module axi_full_mst_burst
    import axi_full_pkg::*;
#(
    parameter int DW  = 64,
    parameter int AW  = 32,
    parameter int IDW = 4,
    parameter int ID  = 0
) (
    input  logic              CLK,
    input  logic              RSTn,
    // command
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic              CMD_WRITE,
    input  logic [AW-1:0]     CMD_ADDR,
    input  logic [7:0]        CMD_LEN,
    // write stream
    input  logic              WR_VALID,
    output logic              WR_READY,
    input  logic [DW-1:0]     WR_DATA,
    input  logic [DW/8-1:0]   WR_STRB,
    // read stream
    output logic              RD_VALID,
    input  logic              RD_READY,
    output logic [DW-1:0]     RD_DATA,
    output logic              RD_LAST,
    // completion
    output logic              DONE,
    output logic [1:0]        DONE_RESP,
    // AXI write address
    output logic [IDW-1:0]    M_AWID,
    output logic [AW-1:0]     M_AWADDR,
    output logic [7:0]        M_AWLEN,
    output logic [2:0]        M_AWSIZE,
    output logic [1:0]        M_AWBURST,
    output logic              M_AWLOCK,
    output logic [3:0]        M_AWCACHE,
    output logic [2:0]        M_AWPROT,
    output logic [3:0]        M_AWQOS,
    output logic              M_AWVALID,
    input  logic              M_AWREADY,
    // AXI write data
    output logic [DW-1:0]     M_WDATA,
    output logic [DW/8-1:0]   M_WSTRB,
    output logic              M_WLAST,
    output logic              M_WVALID,
    input  logic              M_WREADY,
    // AXI write response
    input  logic [IDW-1:0]    M_BID,
    input  logic [1:0]        M_BRESP,
    input  logic              M_BVALID,
    output logic              M_BREADY,
    // AXI read address
    output logic [IDW-1:0]    M_ARID,
    output logic [AW-1:0]     M_ARADDR,
    output logic [7:0]        M_ARLEN,
    output logic [2:0]        M_ARSIZE,
    output logic [1:0]        M_ARBURST,
    output logic              M_ARLOCK,
    output logic [3:0]        M_ARCACHE,
    output logic [2:0]        M_ARPROT,
    output logic [3:0]        M_ARQOS,
    output logic              M_ARVALID,
    input  logic              M_ARREADY,
    // AXI read data
    input  logic [IDW-1:0]    M_RID,
    input  logic [DW-1:0]     M_RDATA,
    input  logic [1:0]        M_RRESP,
    input  logic              M_RLAST,
    input  logic              M_RVALID,
    output logic              M_RREADY
);

    localparam int             NBYTES = DW / 8;
    localparam logic [2:0]     SIZE   = (DW == 64) ? 3'd3 : 3'd2;
    localparam logic [AW-1:0]  AMASK  = AW'(NBYTES - 1);
    localparam logic [IDW-1:0] ID_V   = IDW'(ID);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  resp_q, resp_d;
    logic        rdy_en_q, rdy_en_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]  len_q, len_d;
    logic        cmd_bad;
    logic [1:0]  beat_resp;

    // Worst-of merge for AXI responses (higher encoding is worse).
    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    assign cmd_bad = ((CMD_ADDR & AMASK) != '0) ||
                     crosses_4k(CMD_ADDR[11:0], CMD_LEN, 4'(NBYTES));

    // Address channels carry the latched command; side-band fields fixed.
    assign M_AWID    = ID_V;
    assign M_AWADDR  = addr_q;
    assign M_AWLEN   = len_q;
    assign M_AWSIZE  = SIZE;
    assign M_AWBURST = BURST_INCR;
    assign M_AWLOCK  = 1'b0;
    assign M_AWCACHE = 4'd0;
    assign M_AWPROT  = 3'd0;
    assign M_AWQOS   = 4'd0;
    assign M_ARID    = ID_V;
    assign M_ARADDR  = addr_q;
    assign M_ARLEN   = len_q;
    assign M_ARSIZE  = SIZE;
    assign M_ARBURST = BURST_INCR;
    assign M_ARLOCK  = 1'b0;
    assign M_ARCACHE = 4'd0;
    assign M_ARPROT  = 3'd0;
    assign M_ARQOS   = 4'd0;
    assign M_WDATA   = WR_DATA;
    assign M_WSTRB   = WR_STRB;
    assign RD_DATA   = M_RDATA;
    assign DONE_RESP = resp_q;

    // Next-state, beat counting, response accumulation and handshake outputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        resp_d    = resp_q;
        rdy_en_d  = 1'b1;
        addr_d    = addr_q;
        len_d     = len_q;
        beat_resp = resp_q;
        CMD_READY = 1'b0;
        M_AWVALID = 1'b0;
        M_WVALID  = 1'b0;
        WR_READY  = 1'b0;
        M_WLAST   = 1'b0;
        M_BREADY  = 1'b0;
        M_ARVALID = 1'b0;
        RD_VALID  = 1'b0;
        M_RREADY  = 1'b0;
        RD_LAST   = 1'b0;
        DONE      = 1'b0;
        unique case (state_q)
            IDLE: begin
                CMD_READY = rdy_en_q;
                if (CMD_VALID && rdy_en_q) begin
                    addr_d = CMD_ADDR;
                    len_d  = CMD_LEN;
                    cnt_d  = 8'd0;
                    if (cmd_bad) begin
                        resp_d  = RESP_SLVERR;
                        state_d = FIN;
                    end else begin
                        resp_d  = RESP_OKAY;
                        state_d = CMD_WRITE ? WADDR : RADDR;
                    end
                end
            end
            WADDR: begin
                M_AWVALID = 1'b1;
                if (M_AWREADY) state_d = WDATA;
            end
            WDATA: begin
                M_WVALID = WR_VALID;
                WR_READY = M_WREADY;
                M_WLAST  = (cnt_q == len_q);
                if (WR_VALID && M_WREADY) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == len_q) state_d = WRESP;
                end
            end
            WRESP: begin
                M_BREADY = 1'b1;
                if (M_BVALID) begin
                    // A foreign-ID response is swallowed and flags the burst.
                    if (M_BID != ID_V) begin
                        resp_d = RESP_SLVERR;
                    end else begin
                        resp_d  = resp_max(resp_q, M_BRESP);
                        state_d = FIN;
                    end
                end
            end
            RADDR: begin
                M_ARVALID = 1'b1;
                if (M_ARREADY) state_d = RDATA;
            end
            RDATA: begin
                if (M_RID == ID_V) begin
                    RD_VALID = M_RVALID;
                    M_RREADY = RD_READY;
                    RD_LAST  = M_RLAST;
                    if (M_RVALID && RD_READY) begin
                        beat_resp = resp_max(resp_q, M_RRESP);
                        // RLAST early or missing at the expected beat.
                        if (M_RLAST != (cnt_q == len_q)) beat_resp = RESP_SLVERR;
                        resp_d = beat_resp;
                        if (cnt_q != len_q) cnt_d = cnt_q + 8'd1;
                        if (M_RLAST) state_d = FIN;
                    end
                end else begin
                    M_RREADY = 1'b1;
                    if (M_RVALID) resp_d = RESP_SLVERR;
                end
            end
            FIN: begin
                DONE    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state: FSM, beat counter, response and command-ready enable.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q  <= IDLE;
            cnt_q    <= 8'd0;
            resp_q   <= RESP_OKAY;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            resp_q   <= resp_d;
            rdy_en_q <= rdy_en_d;
        end
    end

    // Latched command address and length; only meaningful after acceptance.
    always_ff @(posedge CLK) begin
        addr_q <= addr_d;
        len_q  <= len_d;
    end

endmodule

// File: tb/tb_axi_full_mst_burst.sv
// Directed bench for axi_full_mst_burst with a small behavioural AXI SRAM slave.
module tb_axi_full_mst_burst;

    logic        CLK, RSTn;
    logic        CMD_VALID, CMD_READY, CMD_WRITE;
    logic [31:0] CMD_ADDR;
    logic [7:0]  CMD_LEN;
    logic        WR_VALID, WR_READY;
    logic [63:0] WR_DATA;
    logic [7:0]  WR_STRB;
    logic        RD_VALID, RD_READY, RD_LAST;
    logic [63:0] RD_DATA;
    logic        DONE;
    logic [1:0]  DONE_RESP;
    logic [3:0]  M_AWID, M_ARID, M_BID, M_RID;
    logic [31:0] M_AWADDR, M_ARADDR;
    logic [7:0]  M_AWLEN, M_ARLEN;
    logic [2:0]  M_AWSIZE, M_ARSIZE, M_AWPROT, M_ARPROT;
    logic [1:0]  M_AWBURST, M_ARBURST, M_BRESP, M_RRESP;
    logic        M_AWLOCK, M_ARLOCK;
    logic [3:0]  M_AWCACHE, M_ARCACHE, M_AWQOS, M_ARQOS;
    logic        M_AWVALID, M_AWREADY, M_ARVALID, M_ARREADY;
    logic [63:0] M_WDATA, M_RDATA;
    logic [7:0]  M_WSTRB;
    logic        M_WLAST, M_WVALID, M_WREADY;
    logic        M_BVALID, M_BREADY;
    logic        M_RLAST, M_RVALID, M_RREADY;

    axi_full_mst_burst dut (
        .CLK(CLK), .RSTn(RSTn),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
        .CMD_ADDR(CMD_ADDR), .CMD_LEN(CMD_LEN),
        .WR_VALID(WR_VALID), .WR_READY(WR_READY), .WR_DATA(WR_DATA), .WR_STRB(WR_STRB),
        .RD_VALID(RD_VALID), .RD_READY(RD_READY), .RD_DATA(RD_DATA), .RD_LAST(RD_LAST),
        .DONE(DONE), .DONE_RESP(DONE_RESP),
        .M_AWID(M_AWID), .M_AWADDR(M_AWADDR), .M_AWLEN(M_AWLEN), .M_AWSIZE(M_AWSIZE),
        .M_AWBURST(M_AWBURST), .M_AWLOCK(M_AWLOCK), .M_AWCACHE(M_AWCACHE),
        .M_AWPROT(M_AWPROT), .M_AWQOS(M_AWQOS), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
        .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WLAST(M_WLAST), .M_WVALID(M_WVALID),
        .M_WREADY(M_WREADY),
        .M_BID(M_BID), .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
        .M_ARID(M_ARID), .M_ARADDR(M_ARADDR), .M_ARLEN(M_ARLEN), .M_ARSIZE(M_ARSIZE),
        .M_ARBURST(M_ARBURST), .M_ARLOCK(M_ARLOCK), .M_ARCACHE(M_ARCACHE),
        .M_ARPROT(M_ARPROT), .M_ARQOS(M_ARQOS), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
        .M_RID(M_RID), .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RLAST(M_RLAST),
        .M_RVALID(M_RVALID), .M_RREADY(M_RREADY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- behavioural SRAM slave ----------------
    logic [63:0] mem [0:63];
    logic        aw_done, b_pend, r_act;
    logic [5:0]  wbase, rbase;
    logic [7:0]  wptr, rbeat, rlen, last_wlast_idx;
    int          aw_wait, aw_stall, r_err_beat;
    int          aw_cnt, ar_cnt, w_beats, wlast_cnt, w_early_cnt;

    initial begin
        aw_cnt = 0; ar_cnt = 0; w_beats = 0; wlast_cnt = 0; w_early_cnt = 0;
    end

    assign M_AWREADY = M_AWVALID && !aw_done && (aw_wait >= aw_stall);
    assign M_WREADY  = aw_done && !b_pend;
    assign M_BVALID  = b_pend;
    assign M_BID     = 4'd0;
    assign M_BRESP   = 2'b00;
    assign M_ARREADY = M_ARVALID && !r_act;
    assign M_RVALID  = r_act;
    assign M_RID     = 4'd0;
    assign M_RDATA   = mem[rbase + rbeat[5:0]];
    assign M_RLAST   = (rbeat == rlen);
    assign M_RRESP   = (int'(rbeat) == r_err_beat) ? 2'b10 : 2'b00;

    always @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            aw_done <= 1'b0; b_pend <= 1'b0; r_act <= 1'b0;
            wptr <= 8'd0; rbeat <= 8'd0; aw_wait <= 0;
            wbase <= 6'd0; rbase <= 6'd0; rlen <= 8'd0;
        end else begin
            if (M_AWVALID && !M_AWREADY) aw_wait <= aw_wait + 1;
            else aw_wait <= 0;
            if (M_WVALID && !aw_done) w_early_cnt <= w_early_cnt + 1;
            if (M_AWVALID && M_AWREADY) begin
                aw_done <= 1'b1; wbase <= M_AWADDR[8:3]; wptr <= 8'd0;
                aw_cnt <= aw_cnt + 1;
            end
            if (M_WVALID && M_WREADY) begin
                for (int b = 0; b < 8; b++)
                    if (M_WSTRB[b]) mem[wbase + wptr[5:0]][b*8 +: 8] <= M_WDATA[b*8 +: 8];
                wptr <= wptr + 8'd1;
                w_beats <= w_beats + 1;
                if (M_WLAST) begin
                    b_pend <= 1'b1; wlast_cnt <= wlast_cnt + 1; last_wlast_idx <= wptr;
                end
            end
            if (M_BVALID && M_BREADY) begin
                b_pend <= 1'b0; aw_done <= 1'b0;
            end
            if (M_ARVALID && M_ARREADY) begin
                r_act <= 1'b1; rbase <= M_ARADDR[8:3]; rlen <= M_ARLEN; rbeat <= 8'd0;
                ar_cnt <= ar_cnt + 1;
            end
            if (M_RVALID && M_RREADY) begin
                rbeat <= rbeat + 8'd1;
                if (M_RLAST) r_act <= 1'b0;
            end
        end
    end

    // ---------------- completion monitor ----------------
    int         done_cnt = 0;
    logic [1:0] done_resp_lat = 2'b00;
    always @(posedge CLK) begin
        if (DONE) begin
            done_cnt      <= done_cnt + 1;
            done_resp_lat <= DONE_RESP;
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Present a command at a falling edge and hold it until accepted.
    task automatic send_cmd(input bit wr, input logic [31:0] addr, input logic [7:0] len);
        bit took;
        took = 1'b0;
        CMD_VALID = 1'b1; CMD_WRITE = wr; CMD_ADDR = addr; CMD_LEN = len;
        for (int c = 0; c < 20 && !took; c++) begin
            #1;
            if (CMD_READY) took = 1'b1;
            @(negedge CLK);
        end
        CMD_VALID = 1'b0;
        check_val("cmd_accept", took, 1);
    endtask

    // Stream n write beats with data start, start+1, ...
    task automatic push_beats(input int n, input logic [63:0] start);
        bit took;
        for (int i = 0; i < n; i++) begin
            took = 1'b0;
            WR_VALID = 1'b1; WR_DATA = start + 64'(i); WR_STRB = 8'hFF;
            for (int c = 0; c < 40 && !took; c++) begin
                #1;
                if (WR_READY) took = 1'b1;
                @(negedge CLK);
            end
            check_val("w_beat_taken", took, 1);
        end
        WR_VALID = 1'b0;
    endtask

    logic [63:0] rd_log [0:7];
    logic [7:0]  rd_last_mask;
    int          rd_count;

    // Accept read beats until RD_LAST or n_max beats, optionally toggling RD_READY.
    task automatic collect(input int n_max, input bit toggle, input int budget);
        bit fin;
        fin = 1'b0; rd_count = 0; rd_last_mask = 8'd0;
        for (int c = 0; c < budget && !fin; c++) begin
            RD_READY = toggle ? ~RD_READY : 1'b1;
            #1;
            if (RD_VALID && RD_READY) begin
                if (rd_count < 8) begin
                    rd_log[rd_count]       = RD_DATA;
                    rd_last_mask[rd_count] = RD_LAST;
                end
                rd_count++;
                if (RD_LAST || rd_count >= n_max) fin = 1'b1;
            end
            @(negedge CLK);
        end
        RD_READY = 1'b0;
    endtask

    task automatic wait_done(input int base, input int budget);
        int c;
        c = 0;
        while (done_cnt == base && c < budget) begin
            @(negedge CLK);
            c++;
        end
        check_val("done_seen", done_cnt > base, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench timeout");
    end

    int  base, aw0, ar0, wb0, wl0;
    bit  hold_ok;

    initial begin
        RSTn = 1'b0; CMD_VALID = 1'b0; CMD_WRITE = 1'b0; CMD_ADDR = '0; CMD_LEN = '0;
        WR_VALID = 1'b0; WR_DATA = '0; WR_STRB = '0; RD_READY = 1'b0;
        aw_stall = 0; r_err_beat = -1;
        repeat (3) @(negedge CLK);

        // Reset state
        check_val("rst_outs", {CMD_READY, M_AWVALID, M_ARVALID, M_WVALID, M_BREADY, M_RREADY,
                               WR_READY, RD_VALID, RD_LAST, M_WLAST, DONE}, 0);
        check_val("rst_resp", DONE_RESP, 0);
        RSTn = 1'b1;
        @(negedge CLK);
        check_val("rdy_after_rst", CMD_READY, 1);

        // Write burst of 4 beats
        base = done_cnt; aw0 = aw_cnt; wb0 = w_beats; wl0 = wlast_cnt;
        send_cmd(1'b1, 32'h8000_0000, 8'd3);
        check_val("t1_awvalid", M_AWVALID, 1);
        check_val("t1_awaddr", M_AWADDR, 64'h8000_0000);
        check_val("t1_awfields", {M_AWLEN, M_AWSIZE, M_AWBURST}, {8'd3, 3'd3, 2'b01});
        check_val("t1_sideband", {M_AWID, M_AWLOCK, M_AWCACHE, M_AWPROT, M_AWQOS,
                                  M_ARID, M_ARLOCK, M_ARCACHE, M_ARPROT, M_ARQOS}, 0);
        push_beats(4, 64'd1);
        wait_done(base, 20);
        check_val("t1_resp", done_resp_lat, 0);
        check_val("t1_done_pulse", {DONE, 32'(done_cnt - base)}, {1'b0, 32'd1});
        check_val("t1_wbeats", w_beats - wb0, 4);
        check_val("t1_wlast_cnt", wlast_cnt - wl0, 1);
        check_val("t1_wlast_beat", last_wlast_idx, 3);
        check_val("t1_aw_cnt", aw_cnt - aw0, 1);
        for (int i = 0; i < 4; i++) check_val("t1_mem", mem[i], 64'(i + 1));

        // Read back with RD_READY toggling
        base = done_cnt;
        send_cmd(1'b0, 32'h8000_0000, 8'd3);
        check_val("t2_arvalid", {M_ARVALID, M_ARLEN, M_ARSIZE, M_ARBURST}, {1'b1, 8'd3, 3'd3, 2'b01});
        collect(4, 1'b1, 60);
        check_val("t2_count", rd_count, 4);
        for (int i = 0; i < 4; i++) check_val("t2_data", rd_log[i], 64'(i + 1));
        check_val("t2_last", rd_last_mask, 8'b0000_1000);
        wait_done(base, 20);
        check_val("t2_resp", done_resp_lat, 0);

        // 4 KB crossing and misalignment: no bus activity, immediate SLVERR
        base = done_cnt; aw0 = aw_cnt; ar0 = ar_cnt;
        send_cmd(1'b1, 32'h8000_0FF8, 8'd1);
        check_val("t3_done", {DONE, DONE_RESP, M_AWVALID}, {1'b1, 2'b10, 1'b0});
        @(negedge CLK);
        check_val("t3_after", {DONE, CMD_READY}, {1'b0, 1'b1});
        check_val("t3_no_aw", aw_cnt - aw0, 0);
        send_cmd(1'b0, 32'h8000_0004, 8'd0);
        check_val("t3_misal", {DONE, DONE_RESP, M_ARVALID}, {1'b1, 2'b10, 1'b0});
        @(negedge CLK);
        check_val("t3_no_ar", ar_cnt - ar0, 0);
        check_val("t3_done_cnt", done_cnt - base, 2);

        // AWREADY held low for 10 cycles
        aw_stall = 10;
        base = done_cnt; aw0 = aw_cnt; wb0 = w_beats;
        WR_VALID = 1'b1; WR_DATA = 64'hA5; WR_STRB = 8'hFF;
        send_cmd(1'b1, 32'h8000_0020, 8'd0);
        hold_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (!(M_AWVALID && M_AWADDR == 32'h8000_0020 && M_AWLEN == 8'd0 && !WR_READY))
                hold_ok = 1'b0;
            @(negedge CLK);
        end
        check_val("t4_aw_hold", hold_ok, 1);
        check_val("t4_no_early", {32'(aw_cnt - aw0), 32'(w_beats - wb0)}, 0);
        push_beats(1, 64'hA5);
        wait_done(base, 20);
        check_val("t4_resp", done_resp_lat, 0);
        check_val("t4_mem", mem[4], 64'hA5);
        aw_stall = 0;

        // SLVERR on the second read beat
        r_err_beat = 1;
        base = done_cnt;
        send_cmd(1'b0, 32'h8000_0000, 8'd3);
        collect(4, 1'b0, 40);
        check_val("t5_count", rd_count, 4);
        check_val("t5_data3", rd_log[3], 64'd4);
        check_val("t5_last", rd_last_mask, 8'b0000_1000);
        wait_done(base, 20);
        check_val("t5_resp", done_resp_lat, 2'b10);
        r_err_beat = -1;

        // Reset in the middle of a write data phase
        send_cmd(1'b1, 32'h8000_0040, 8'd3);
        push_beats(1, 64'h11);
        WR_VALID = 1'b1; WR_DATA = 64'h12;
        #1;
        check_val("t6_in_wdata", M_WVALID, 1);
        RSTn = 1'b0;
        #1;
        check_val("t6_rst_outs", {CMD_READY, M_AWVALID, M_ARVALID, M_WVALID, M_BREADY, M_RREADY,
                                  WR_READY, RD_VALID, RD_LAST, M_WLAST, DONE}, 0);
        check_val("t6_rst_resp", DONE_RESP, 0);
        repeat (2) @(negedge CLK);
        RSTn = 1'b1; WR_VALID = 1'b0;
        @(negedge CLK);
        check_val("t6_rdy", CMD_READY, 1);
        base = done_cnt;
        send_cmd(1'b0, 32'h8000_0000, 8'd0);
        collect(1, 1'b0, 20);
        check_val("t6_rd", {32'(rd_count), rd_log[0]}, {32'd1, 64'd1});
        check_val("t6_last", rd_last_mask, 8'b0000_0001);
        wait_done(base, 20);
        check_val("t6_resp", done_resp_lat, 0);

        check_val("w_before_aw", w_early_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
